// File: rtl/i2c_start_gen.sv
// Open-drain I2C START / repeated-START generator for the master bit engine.
// Releases both lines, waits out stretching or a busy bus, then drops SDA and SCL in turn.
module i2c_start_gen #(
  parameter int CLK_FREQ = 25_000_000,
  parameter int I2C_FREQ = 100_000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_req,
  input  logic i_enable,
  output logic o_done,
  output logic o_ready,
  input  logic i_sda,
  input  logic i_scl,
  output logic o_sda_drive,
  output logic o_scl_drive
);

  localparam int TQ_DIV = CLK_FREQ / (4 * I2C_FREQ);
  localparam int TQ     = (TQ_DIV < 1) ? 1 : TQ_DIV;
  localparam int CW     = $clog2(TQ + 1);
  localparam logic [CW-1:0] TQ_LOAD = CW'(TQ - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_REL_SDA = 3'd1;
  localparam logic [2:0] S_REL_SCL = 3'd2;
  localparam logic [2:0] S_SDA_LOW = 3'd3;
  localparam logic [2:0] S_SCL_LOW = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  logic [2:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_done;
  logic          r_ready;
  logic          r_sda;
  logic          r_scl;

  logic w_tc;
  logic w_bus_high;

  assign w_tc       = (r_cnt == '0);
  assign w_bus_high = i_sda & i_scl;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_ready <= 1'b1;
      r_sda   <= 1'b1;
      r_scl   <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_req && i_enable) begin
            r_state <= S_REL_SDA;
            r_cnt   <= TQ_LOAD;
            r_ready <= 1'b0;
            r_sda   <= 1'b1;
          end
        end
        S_DONE: begin
          if (!i_req) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
            r_ready <= 1'b1;
          end
        end
        default: begin
          if (!i_enable) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_done  <= 1'b0;
            r_ready <= 1'b1;
            r_sda   <= 1'b1;
            r_scl   <= 1'b1;
          end else begin
            case (r_state)
              // SCL is left as-is here so a held-low clock cannot turn SDA's release into a STOP
              S_REL_SDA: begin
                if (w_tc) begin
                  r_state <= S_REL_SCL;
                  r_cnt   <= TQ_LOAD;
                  r_scl   <= 1'b1;
                  r_sda   <= 1'b1;
                end else begin
                  r_cnt <= r_cnt - CW'(1);
                end
              end
              S_REL_SCL: begin
                if (!w_bus_high) begin
                  r_cnt <= TQ_LOAD;
                end else if (w_tc) begin
                  r_state <= S_SDA_LOW;
                  r_cnt   <= TQ_LOAD;
                  r_sda   <= 1'b0;
                end else begin
                  r_cnt <= r_cnt - CW'(1);
                end
              end
              S_SDA_LOW: begin
                if (w_tc) begin
                  r_state <= S_SCL_LOW;
                  r_cnt   <= TQ_LOAD;
                  r_scl   <= 1'b0;
                end else begin
                  r_cnt <= r_cnt - CW'(1);
                end
              end
              S_SCL_LOW: begin
                if (w_tc) begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
                end else begin
                  r_cnt <= r_cnt - CW'(1);
                end
              end
              default: begin
                r_state <= S_IDLE;
                r_ready <= 1'b1;
                r_done  <= 1'b0;
                r_sda   <= 1'b1;
                r_scl   <= 1'b1;
              end
            endcase
          end
        end
      endcase
    end
  end

  assign o_done      = r_done;
  assign o_ready     = r_ready;
  assign o_sda_drive = r_sda;
  assign o_scl_drive = r_scl;

endmodule

// File: tb/tb_i2c_start_gen.sv
// Bench for i2c_start_gen: wired-AND bus with external pull-downs, a phase/elapsed-time
// model compared every cycle, plus directed literal checks and a START/STOP bus monitor.
module tb_i2c_start_gen;

  localparam int TQ = 6;

  logic i_clk = 1'b0;
  logic i_rst, i_req, i_enable;
  logic ext_sda, ext_scl;
  logic o_done, o_ready, o_sda_drive, o_scl_drive;
  logic bus_sda, bus_scl;

  assign bus_sda = o_sda_drive & ext_sda;
  assign bus_scl = o_scl_drive & ext_scl;

  i2c_start_gen #(.CLK_FREQ(25_000_000), .I2C_FREQ(1_000_000)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req), .i_enable(i_enable),
    .o_done(o_done), .o_ready(o_ready), .i_sda(bus_sda), .i_scl(bus_scl),
    .o_sda_drive(o_sda_drive), .o_scl_drive(o_scl_drive)
  );

  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  function automatic logic [3:0] outs();
    return {o_done, o_ready, o_sda_drive, o_scl_drive};
  endfunction

  // Model: phase 0 idle, 1 release SDA, 2 release SCL / setup, 3 START hold, 4 SCL low, 5 done.
  int   m_phase = 0;
  int   m_elapsed = 0;
  logic m_done = 0, m_ready = 1, m_sda = 1, m_scl = 1;

  always @(posedge i_clk) begin
    if (i_rst) begin
      m_phase = 0; m_elapsed = 0;
      m_done = 0; m_ready = 1; m_sda = 1; m_scl = 1;
    end else if (m_phase == 0) begin
      if (i_req && i_enable) begin
        m_phase = 1; m_elapsed = 0; m_ready = 0; m_sda = 1;
      end
    end else if (m_phase == 5) begin
      if (!i_req) begin
        m_phase = 0; m_done = 0; m_ready = 1;
      end
    end else if (!i_enable) begin
      m_phase = 0; m_elapsed = 0;
      m_done = 0; m_ready = 1; m_sda = 1; m_scl = 1;
    end else if (m_phase == 2) begin
      if ((m_sda & ext_sda) && (m_scl & ext_scl)) m_elapsed++;
      else m_elapsed = 0;
      if (m_elapsed == TQ) begin
        m_phase = 3; m_elapsed = 0; m_sda = 0;
      end
    end else begin
      m_elapsed++;
      if (m_elapsed == TQ) begin
        m_elapsed = 0;
        case (m_phase)
          1: begin m_phase = 2; m_sda = 1; m_scl = 1; end
          3: begin m_phase = 4; m_scl = 0; end
          default: begin m_phase = 5; m_done = 1; end
        endcase
      end
    end
  end

  bit cmp_on = 0;
  always @(negedge i_clk)
    if (cmp_on) chk("model", outs(), {m_done, m_ready, m_sda, m_scl});

  // Bus monitor: SDA edges while SCL stays high.
  int   n_start = 0, n_stop = 0;
  logic p_sda = 1, p_scl = 1;
  always @(posedge i_clk) begin
    if (p_scl && bus_scl && p_sda && !bus_sda) n_start++;
    if (p_scl && bus_scl && !p_sda && bus_sda) n_stop++;
    p_sda = bus_sda;
    p_scl = bus_scl;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic wait_ready_low(input string name);
    int k = 0;
    while (o_ready !== 1'b0 && k < 10) begin @(negedge i_clk); k++; end
    if (o_ready !== 1'b0) chk({name, "_ready_timeout"}, {3'b0, o_ready}, 4'b0000);
  endtask

  task automatic wait_done(input string name, output int lat);
    lat = 0;
    while (o_done !== 1'b1 && lat < 300) begin @(negedge i_clk); lat++; end
    if (o_done !== 1'b1) chk({name, "_done_timeout"}, {3'b0, o_done}, 4'b0001);
  endtask

  int lat;
  int k;

  initial begin
    i_rst = 1; i_req = 0; i_enable = 1; ext_sda = 1; ext_scl = 1;
    cyc(2);
    cmp_on = 1;
    i_rst = 0;
    cyc(1);
    chk("reset", outs(), 4'b0111);

    // SCL held low by a slave, SDA high
    ext_scl = 0; i_req = 1;
    wait_ready_low("t1");
    ext_scl = 1;
    wait_done("t1", lat);
    cyc(1);
    chk("t1_lines_low", outs(), 4'b1000);
    i_req = 0;
    cyc(4);
    chk("t1_after_drop", outs(), 4'b0100);

    // both lines held low externally, repeated start from held-low bus
    ext_scl = 0; ext_sda = 0;
    cyc(1);
    i_req = 1;
    wait_ready_low("t2");
    ext_scl = 1; ext_sda = 1;
    wait_done("t2", lat);
    cyc(1);
    chk("t2_lines_low", outs(), 4'b1000);
    i_req = 0;
    cyc(4);
    chk("t2_after_drop", outs(), 4'b0100);

    // idle bus: latency 4*TQ+1 from the accepting edge
    i_req = 1;
    wait_done("t3", lat);
    chk("t3_latency", 4'(lat), 4'(4 * TQ + 1));
    chk("t3_lines", outs(), 4'b1000);
    i_req = 0;
    cyc(2);

    // another master holds SDA low with SCL high
    ext_sda = 0;
    i_req = 1;
    for (k = 0; k < 16; k++) begin
      cyc(1);
      chk("t4_busy", {o_done, o_ready, 2'b00}, 4'b0000);
    end
    chk("t4_released", outs(), 4'b0011);

    // enable drop while waiting in REL_SCL
    i_enable = 0;
    cyc(1);
    chk("t5_abort", outs(), 4'b0111);
    i_req = 0;
    ext_scl = 0; cyc(1);
    ext_sda = 1; cyc(1);
    ext_scl = 1; cyc(1);

    // disabled block ignores requests
    i_req = 1;
    cyc(5);
    chk("t5_disabled", outs(), 4'b0111);
    i_req = 0;
    i_enable = 1;
    cyc(1);

    // request withdrawn mid-sequence still completes
    i_req = 1;
    cyc(3);
    i_req = 0;
    k = 0;
    while (o_done !== 1'b1 && k < 100) begin cyc(1); k++; end
    chk("t6_done_seen", {3'b0, o_done}, 4'b0001);
    cyc(1);
    chk("t6_back_idle", outs(), 4'b0100);

    // reset while in SCL_LOW (from idle-released start: drives 00, not done)
    i_rst = 1; cyc(1); i_rst = 0; cyc(1);
    i_req = 1;
    k = 0;
    while (!(o_sda_drive === 1'b0 && o_scl_drive === 1'b0) && k < 100) begin cyc(1); k++; end
    chk("t7_in_scl_low", outs(), 4'b0000);
    i_rst = 1;
    cyc(1);
    chk("t7_reset", outs(), 4'b0111);
    i_rst = 0; i_req = 0;
    cyc(3);

    chk("bus_stops", 4'(n_stop), 4'd0);
    chk("bus_starts", 4'(n_start), 4'd5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/i2c_start_gen.md
Name: i2c_start_gen

Overview:
- Open-drain I2C START (and repeated-START) condition generator used by the I2C master's bit-level engine.
- On request, from any bus state (SCL high or low, SDA high or low), it:
  - releases SDA;
  - releases SCL and waits for both lines high, allowing clock stretching and another master holding the bus;
  - pulls SDA low while SCL is high;
  - then pulls SCL low.
- It completes with both lines held low, ready for the first data bit.

Parameters:
- CLK_FREQ, 25_000_000, system clock frequency in Hz.
- I2C_FREQ, 100_000, target SCL frequency in Hz.
- Derived (localparam): TQ = max(1, CLK_FREQ/(4*I2C_FREQ)), the quarter-period in clocks.
- Counter width is $clog2(TQ+1).

Ports:
- i_clk  in  1  system clock; single clock domain, all logic on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_req  in  1  start request (level; held until o_done is seen).
- i_enable  in  1  block enable; 0 blocks acceptance and aborts an operation.
- o_done  out  1  start complete; held high while i_req remains high.
- o_ready  out  1  idle and able to accept i_req.
- i_sda  in  1  sampled SDA bus line.
- i_scl  in  1  sampled SCL bus line.
- o_sda_drive  out  1  1 = release SDA (high-Z), 0 = pull SDA low.
- o_scl_drive  out  1  1 = release SCL (high-Z), 0 = pull SCL low.

Behaviour:
- Reset values: state IDLE, counter 0, o_done=0, o_ready=1, o_sda_drive=1, o_scl_drive=1.
- Registered outputs; the quarter-period counter reloads on each state entry.
- IDLE:
  - o_ready=1; drive outputs keep their last value (released after reset, both low after a completed start).
  - i_req & i_enable -> REL_SDA; o_ready drops the next cycle.
- REL_SDA:
  - o_sda_drive=1; o_scl_drive unchanged, so SCL held low stays low and no STOP is created.
  - Wait TQ clocks -> REL_SCL.
- REL_SCL:
  - o_scl_drive=1, o_sda_drive=1.
  - Stay while i_scl=0 (stretching) or i_sda=0 (bus busy / another master); no timeout.
  - When both read 1, wait TQ clocks with both still high (setup) -> SDA_LOW.
  - If either line drops during the count, restart the count.
- SDA_LOW: o_sda_drive=0 (START edge); wait TQ clocks (hold) -> SCL_LOW.
- SCL_LOW: o_scl_drive=0; wait TQ clocks -> DONE.
- DONE:
  - o_done=1, o_ready=0; both drives held 0.
  - When i_req=0 -> IDLE (o_done=0, drives stay 0).
- i_enable=0 in any non-IDLE, non-DONE state -> IDLE immediately with both drives released (1), o_done=0.
- i_req dropping mid-sequence is ignored; the sequence completes.
- Reset mid-operation returns to reset values on the next edge.
- Latency from acceptance to o_done:
  - lines free: 4*TQ + 2 clocks (±1);
  - otherwise extended by the time spent waiting in REL_SCL.

Test Plan:
- CLK_FREQ=25e6, I2C_FREQ=1e6 (TQ=6); SCL held low externally, SDA high; assert i_req; release SCL once o_ready=0 -> o_done asserts; 1 cycle later sda=0, scl=0; drop i_req; 4 cycles later still sda=0, scl=0, o_done=0, o_ready=1.
- Same, but SDA and SCL both held low externally, released after o_ready=0 -> same result; no SDA rise while SCL high before the START edge.
- Bus idle (both high), i_req=1 -> SDA falls while SCL high, then SCL falls TQ later; o_done observed after ~26 clocks; both lines low.
- SDA held low, SCL high (other master), i_req=1 -> o_ready=0 on each of the following 4+ cycles; o_done never asserts; drives stay released.
- i_enable dropped during REL_SCL -> IDLE, o_sda_drive=o_scl_drive=1, o_ready=1 next cycle.
- i_rst=1 in SCL_LOW -> next cycle o_done=0, o_ready=1, both drives 1.
